mem_arb_nport: RTL and testbench

- Parametrised successor to the single-port valid/ready memory.
- NUM_PORTS independent requesters share one synchronous storage array through a round-robin arbiter.
- Configurable wait states and out-of-range address detection.
- Sits between bus masters and on-chip storage; array is named mem so benches can do $readmemh/$writememh backdoor access.

---
 rtl/mem_arb_nport.sv | 173 +++++++++++++++++
 tb/tb_mem_arb_nport.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_nport.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_nport
// Description : NUM_PORTS valid/ready requesters sharing one synchronous
//               storage array (mem) through a round-robin arbiter, with
//               configurable wait states and out-of-range address detection.
//               Optional macro MEM_ARB_PARITY_EN adds an even-parity bit per
//               word; a parity mismatch on read raises err with ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_nport #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int NUM_PORTS   = 2,
    parameter int WAIT_STATES = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             valid,
    input  logic [NUM_PORTS-1:0]             wr_rd,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_PORTS*WIDTH-1:0]       wdata,
    output logic [NUM_PORTS*WIDTH-1:0]       rdata,
    output logic [NUM_PORTS-1:0]             ready,
    output logic [NUM_PORTS-1:0]             err
);

    localparam int c_GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
`ifdef MEM_ARB_PARITY_EN
    localparam int c_MW = WIDTH + 1;
`else
    localparam int c_MW = WIDTH;
`endif

    localparam logic [1:0]      c_ST_IDLE   = 2'd0;
    localparam logic [1:0]      c_ST_ACCESS = 2'd1;
    localparam logic [1:0]      c_ST_RESP   = 2'd2;
    localparam logic [c_GW-1:0] c_LAST_INIT = c_GW'(NUM_PORTS - 1);
    localparam logic [2:0]      c_WAIT      = 3'(WAIT_STATES);

    // Storage array; name is fixed so benches can reach it for backdoor access
    logic [c_MW-1:0] mem [0:DEPTH-1];

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [c_GW-1:0]       r_grant;
    logic [c_GW-1:0]       r_last_grant;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]      r_wdata;
    logic [2:0]            r_cnt;
    logic                  r_err;

    logic [c_GW-1:0]       w_pick;
    logic [c_GW-1:0]       w_idx;
    logic                  w_found;
    logic                  w_oor;
    logic                  w_par_err;
    logic                  w_err;
    logic                  w_do_access;
    logic [c_MW-1:0]       w_rd_word;

    // Out-of-range detection only exists when the address space exceeds DEPTH
    generate
        if (DEPTH < (2 ** ADDR_WIDTH)) begin : g_oor
            localparam logic [ADDR_WIDTH:0] c_DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
            assign w_oor = ({1'b0, r_addr} >= c_DEPTH_EXT);
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_do_access = (r_state == c_ST_ACCESS) && (r_cnt == 3'd0);
    assign w_rd_word   = w_oor ? '0 : mem[r_addr];

`ifdef MEM_ARB_PARITY_EN
    // Even parity: data bits plus stored parity bit must XOR to zero
    assign w_par_err = !w_oor && !r_wr && (^w_rd_word);
`else
    assign w_par_err = 1'b0;
`endif
    assign w_err = w_oor | w_par_err;

    // Round-robin pick: first requesting port after the last one served
    always_comb begin
        w_pick  = r_last_grant;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_idx = c_GW'((int'(r_last_grant) + i) % NUM_PORTS);
            if (!w_found && valid[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; valid is only looked at in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (|valid) w_state_next = c_ST_ACCESS;
            c_ST_ACCESS: if (r_cnt == 3'd0) w_state_next = c_ST_RESP;
            c_ST_RESP:   w_state_next = c_ST_IDLE;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    // Response outputs: one-cycle pulse on the granted port while in RESP
    always_comb begin
        ready = '0;
        err   = '0;
        if (r_state == c_ST_RESP) begin
            ready[r_grant] = 1'b1;
            err[r_grant]   = r_err;
        end
    end

    // Request latch, wait counter, grant history and per-port read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= c_LAST_INIT;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= 3'd0;
            r_err        <= 1'b0;
            rdata        <= '0;
        end else begin
            if (r_state == c_ST_IDLE && (|valid)) begin
                r_grant <= w_pick;
                r_wr    <= wr_rd[w_pick];
                r_addr  <= addr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
                r_wdata <= wdata[w_pick*WIDTH +: WIDTH];
                r_cnt   <= c_WAIT;
            end else if (r_state == c_ST_ACCESS) begin
                if (r_cnt != 3'd0) begin
                    r_cnt <= r_cnt - 3'd1;
                end else begin
                    r_last_grant <= r_grant;
                    r_err        <= w_err;
                    if (!r_wr) begin
                        rdata[r_grant*WIDTH +: WIDTH] <= w_rd_word[WIDTH-1:0];
                    end
                end
            end
        end
    end

    // Array write; an async reset forces IDLE first, so an abandoned access never writes
    always_ff @(posedge clk) begin
        if (w_do_access && r_wr && !w_oor) begin
`ifdef MEM_ARB_PARITY_EN
            mem[r_addr] <= {^r_wdata, r_wdata};
`else
            mem[r_addr] <= r_wdata;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arb_nport.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arb_nport
// Description : Randomised scoreboard bench for mem_arb_nport (DEPTH=12 so the
//               out-of-range path is reachable, WAIT_STATES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arb_nport;

    localparam int W  = 8;
    localparam int D  = 12;
    localparam int AW = 4;
    localparam int NP = 2;
    localparam int WS = 2;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic [NP-1:0]     valid = '0;
    logic [NP-1:0]     wr_rd = '0;
    logic [NP*AW-1:0]  addr  = '0;
    logic [NP*W-1:0]   wdata = '0;
    logic [NP*W-1:0]   rdata;
    logic [NP-1:0]     ready;
    logic [NP-1:0]     err;

    mem_arb_nport #(
        .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .NUM_PORTS(NP), .WAIT_STATES(WS)
    ) dut (
        .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         port;
        logic [W-1:0] rd;
        logic       er;
        int         cyc;
    } exp_t;
    exp_t exq[$];
    exp_t mon_e;

    // Reference model: word array, per-port last read value, last served port
    logic [W-1:0] m_mem [D];
    logic         m_bad [D];
    logic [W-1:0] m_rd  [NP];
    int           m_last;

    logic         t_wr   [NP];
    logic [AW-1:0] t_addr [NP];
    logic [W-1:0] t_data [NP];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every ready pulse must match the oldest predicted completion
    always @(negedge clk) begin
        if (!rst && ready != '0) begin
            if (exq.size() == 0) begin
                check("unexpected_ready", 32'(ready), 32'd0);
            end else begin
                mon_e = exq.pop_front();
                check("grant_port", 32'(ready), 32'd1 << mon_e.port);
                check("err_flag", 32'(err), mon_e.er ? (32'd1 << mon_e.port) : 32'd0);
                check("rdata", 32'(rdata[mon_e.port*W +: W]), 32'(mon_e.rd));
                check("latency", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic set_op(input int p, input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
        t_wr[p]   = wr;
        t_addr[p] = a;
        t_data[p] = d;
    endtask

    // Issue one request per enabled port, predict service order and results,
    // then hold each request until that port sees ready.
    task automatic do_round(input logic [NP-1:0] en);
        int c0;
        int k;
        int lastp;
        int n;
        logic [NP-1:0] pend;
        c0    = cyc;
        k     = 0;
        lastp = m_last;
        for (int j = 1; j <= NP; j++) begin
            int   p;
            exp_t e;
            logic oor;
            p   = (m_last + j) % NP;
            if (en[p]) begin
                oor  = (int'(t_addr[p]) >= D);
                e.er = oor;
                if (t_wr[p]) begin
                    if (!oor) begin
                        m_mem[t_addr[p]] = t_data[p];
                        m_bad[t_addr[p]] = 1'b0;
                    end
                end else if (oor) begin
                    m_rd[p] = '0;
                end else begin
                    m_rd[p] = m_mem[t_addr[p]];
                    e.er    = m_bad[t_addr[p]];
                end
                e.port = p;
                e.rd   = m_rd[p];
                e.cyc  = c0 + WS + 2 + k * (WS + 3);
                exq.push_back(e);
                k++;
                lastp = p;
            end
        end
        m_last = lastp;
        for (int p = 0; p < NP; p++) begin
            valid[p]          = en[p];
            wr_rd[p]          = t_wr[p];
            addr[p*AW +: AW]  = t_addr[p];
            wdata[p*W +: W]   = t_data[p];
        end
        pend = en;
        n    = 0;
        while (pend != '0 && n < 200) begin
            @(negedge clk);
            n++;
            pend  = pend & ~ready;
            valid = valid & ~ready;
        end
        if (pend != '0) begin
            check("round_timeout", 32'(pend), 32'd0);
            valid = '0;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < D; i++) begin
            m_mem[i] = '0;
            m_bad[i] = 1'b0;
        end
        for (int p = 0; p < NP; p++) begin
            m_rd[p] = '0;
            set_op(p, 1'b0, '0, '0);
        end
        m_last = NP - 1;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_rdata", 32'(rdata), 32'd0);

        // Full-depth sweep on port 1
        for (int a = 0; a < D; a++) begin
            set_op(1, 1'b1, AW'(a), W'($urandom_range(100, 200)));
            do_round(2'b10);
        end
        for (int a = 0; a < D; a++) begin
            set_op(1, 1'b0, AW'(a), '0);
            do_round(2'b10);
        end

        // Port 0 write then read of the top address
        set_op(0, 1'b1, AW'(D - 1), 8'hA5);
        do_round(2'b01);
        set_op(0, 1'b0, AW'(D - 1), '0);
        do_round(2'b01);

        // Contention on addr 3 with port 1 served last beforehand
        set_op(1, 1'b0, 4'd5, '0);
        do_round(2'b10);
        set_op(0, 1'b1, 4'd3, 8'h11);
        set_op(1, 1'b1, 4'd3, 8'h22);
        do_round(2'b11);
        set_op(0, 1'b0, 4'd3, '0);
        do_round(2'b01);

        // Continuous requests from both ports
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < NP; p++)
                set_op(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)), W'($urandom));
            do_round(2'b11);
        end

        // Out-of-range read and write
        set_op(0, 1'b0, 4'd13, '0);
        do_round(2'b01);
        set_op(1, 1'b1, 4'd14, 8'h77);
        do_round(2'b10);

        // Random mix
        for (int r = 0; r < 40; r++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 7) == 0)
                    set_op(p, 1'($urandom_range(0, 1)), AW'($urandom_range(D, 15)), W'($urandom));
                else
                    set_op(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)), W'($urandom));
            end
            do_round(NP'($urandom_range(1, 3)));
        end

        // Reset during the second ACCESS cycle of a write
        valid[0]         = 1'b1;
        wr_rd[0]         = 1'b1;
        addr[0 +: AW]    = 4'd2;
        wdata[0 +: W]    = 8'h5A;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        valid = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < NP; p++) m_rd[p] = '0;
        m_last = NP - 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_ready_after_reset", 32'(ready), 32'd0);
        end
        check("rdata_after_reset", 32'(rdata), 32'd0);
        set_op(0, 1'b0, 4'd2, '0);
        set_op(1, 1'b0, 4'd2, '0);
        do_round(2'b11);

`ifdef MEM_ARB_PARITY_EN
        // Corrupt one stored data bit behind the arbiter's back
        dut.mem[4] = dut.mem[4] ^ 9'h001;
        m_mem[4]   = m_mem[4] ^ 8'h01;
        m_bad[4]   = 1'b1;
        set_op(0, 1'b0, 4'd4, '0);
        do_round(2'b01);
`endif

        for (int i = 0; i < D; i++)
            check("mem_backdoor", 32'(dut.mem[i][W-1:0]), 32'(m_mem[i]));
        check("pending_expected", 32'(exq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
